// File: rtl/lfsr_word_gen.sv
// Fibonacci LFSR word generator: BPC feedback steps per clock, packed into OUT_W-bit words on valid/ready.
// Optional LFSR_LOCKUP_RECOVER_EN: a zero seed load is replaced by SEED and flagged on lockup.
module lfsr_word_gen #(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = 32'h88000140,
  parameter logic [WIDTH-1:0] SEED  = 32'h00000001,
  parameter int unsigned      OUT_W = 8,
  parameter int unsigned      BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [OUT_W-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lockup
);

  localparam int unsigned      STEPS    = OUT_W / BPC;
  localparam int unsigned      CNT_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GEN,
    S_VALID
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_word;
  logic [OUT_W-1:0] r_out_word;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_data_nxt;
  logic [OUT_W-1:0] w_word_nxt;
  logic             w_fb;
  logic [WIDTH-1:0] w_load_val;
  logic             w_gen_step;
  logic             w_last;

  // BPC shift steps unrolled; each feedback bit also enters the word from the LSB side
  always_comb begin
    w_fb       = 1'b0;
    w_data_nxt = r_data;
    w_word_nxt = r_word;
    for (int unsigned i = 0; i < BPC; i++) begin
      w_fb       = ^(w_data_nxt & POLY);
      w_data_nxt = {w_data_nxt[WIDTH-2:0], w_fb};
      w_word_nxt = {w_word_nxt[OUT_W-2:0], w_fb};
    end
  end

`ifdef LFSR_LOCKUP_RECOVER_EN
  logic w_zero_seed;
  logic r_lockup;

  assign w_zero_seed = (load_data == '0);
  assign w_load_val  = w_zero_seed ? SEED : load_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lockup <= 1'b0;
    end else begin
      r_lockup <= load & w_zero_seed;
    end
  end

  assign lockup = r_lockup;
`else
  assign w_load_val = load_data;
  assign lockup     = 1'b0;
`endif

  assign w_gen_step = (r_state == S_GEN) && en && !load;
  assign w_last     = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    if (load) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (en) w_state_nxt = S_GEN;
        S_GEN:   if (en && w_last) w_state_nxt = S_VALID;
        S_VALID: if (out_ready) w_state_nxt = en ? S_GEN : S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data      <= SEED;
      r_cnt       <= '0;
      r_word      <= '0;
      r_out_word  <= '0;
      r_out_valid <= 1'b0;
    end else if (load) begin
      r_data      <= w_load_val;
      r_cnt       <= '0;
      r_word      <= '0;
      r_out_valid <= 1'b0;
    end else if (w_gen_step) begin
      r_data <= w_data_nxt;
      r_word <= w_word_nxt;
      if (w_last) begin
        r_out_word  <= w_word_nxt;
        r_out_valid <= 1'b1;
        r_cnt       <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else if ((r_state == S_VALID) && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_word  = r_out_word;
  assign out_valid = r_out_valid;

endmodule
